dmem_access_ctrl: RTL

//  Load/store initiator between the datapath MEM stage and the word-only DMEM data segment.
//  - Accepts one byte/half/word load or store per handshake.
//  - Range- and alignment-checks the address.
//  - Drives DMEM read/write controls.
//  - Performs read-modify-write for sub-word stores.
//  - Returns one response: data or error.

---
 rtl/dmem_access_ctrl_if.sv | 32 +++
 rtl/dmem_access_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Purpose: request/response and DMEM-side signals of the load/store controller.
// Latency: none, wiring only.
// Backpressure: req_ready from the controller gates request acceptance.
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Environment side: datapath issuing requests plus the DMEM returning read data.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_read, mem_write, mem_addr, mem_wdata
  );

  // Controller side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Purpose: byte/half/word load-store initiator for a word-only DMEM, with range/alignment checks and RMW.
// Latency: error 1, load WAIT_CYCLES+1, word store 3, sub-word store WAIT_CYCLES+3 cycles to rsp_valid.
// Backpressure: one request outstanding; req_ready is high only while idle.
module dmem_access_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          NUM_WORDS   = 32,
  parameter int          WAIT_CYCLES = 2
) (
  input logic           clk,
  input logic           reset,
  dmem_access_ctrl_if.slave bus
);

  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * NUM_WORDS) - 32'd1;
  localparam logic [7:0]  READ_LAST = 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        wr_q, sgn_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] wdata_q, mem_addr_q, mem_wdata_q, rsp_rdata_q;
  logic        rsp_error_q;
  logic        acc_err, accept;

  // Select the addressed lane of a fetched word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sg, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = 16'(w >> {off[1], 4'b0000});
    case (sz)
      2'b00:   return sg ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   return sg ? {{16{h[15]}}, h} : {16'b0, h};
      default: return w;
    endcase
  endfunction

  // Overlay the low bits of the store data onto the addressed lane of the fetched word.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = w;
    case (sz)
      2'b00:   m[{off, 3'b000} +: 8] = d[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = d[15:0];
      default: m = d;
    endcase
    return m;
  endfunction

  assign acc_err = (bus.req_addr < BASE_ADDR) || (bus.req_addr > LAST_ADDR) ||
                   (bus.req_size == 2'b11) ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign accept  = (state == IDLE) && bus.req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode and the control strobes, which follow the state directly.
  always_comb begin
    state_n       = state;
    bus.req_ready = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (acc_err)                                     state_n = RESP;
          else if (bus.req_write && bus.req_size == 2'b10) state_n = WRITE;
          else                                             state_n = READ;
        end
      end
      READ: begin
        bus.mem_read = 1'b1;
        if (cnt == READ_LAST) state_n = wr_q ? WRITE : RESP;
      end
      WRITE: begin
        // Two write cycles so DMEM's delayed write sampling still sees stable data.
        bus.mem_write = 1'b1;
        if (cnt == 8'd1) state_n = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Request capture, dwell counter, DMEM address/data and the held response fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      wr_q        <= 1'b0;
      sgn_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      cnt <= (state_n != state) ? 8'd0 : cnt + 8'd1;
      if (accept) begin
        wr_q    <= bus.req_write;
        sgn_q   <= bus.req_signed;
        size_q  <= bus.req_size;
        off_q   <= bus.req_addr[1:0];
        wdata_q <= bus.req_wdata;
        if (acc_err) begin
          rsp_error_q <= 1'b1;
          rsp_rdata_q <= '0;
        end else begin
          mem_addr_q <= {bus.req_addr[31:2], 2'b00};
          if (bus.req_write && bus.req_size == 2'b10) mem_wdata_q <= bus.req_wdata;
        end
      end
      if (state == READ && state_n == RESP) begin
        rsp_rdata_q <= load_extract(bus.mem_rdata, size_q, sgn_q, off_q);
        rsp_error_q <= 1'b0;
      end
      if (state == READ && state_n == WRITE)
        mem_wdata_q <= store_merge(bus.mem_rdata, wdata_q, size_q, off_q);
      if (state == WRITE && state_n == RESP) begin
        rsp_rdata_q <= '0;
        rsp_error_q <= 1'b0;
      end
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;

endmodule
